program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time loader directly upstream of the processor core.
- Accepts a byte stream over a valid/ready handshake, packs big-endian 16-bit instruction words and writes them into instruction memory from address 0.
- Holds the core in reset during loading; releases it a fixed number of cycles after the last write.

Parameters:
ADDR_W, 16, width of imem_addr (matches the 16-bit PC)
DEPTH, 256, maximum words accepted; declared length above this is an error
HOLD_CYCLES, 4, cycles core_reset stays high after the final write, before release

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored while busy
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts a byte this cycle
imem_addr  output  ADDR_W  instruction memory write address
imem_data  output  16  instruction word to write
imem_we  output  1  instruction memory write strobe, one cycle per word
core_reset  output  1  reset to the pipeline core, active-high
busy  output  1  high in every state except IDLE, DONE, ERROR
done  output  1  high in DONE
err  output  1  high in ERROR

Behaviour:
- Reset (async) values: state IDLE, imem_addr=0, imem_data=0, imem_we=0, byte_ready=0, core_reset=1, busy=0, done=0, err=0, word count=0, hold counter=0.
- A byte transfers on a rising edge with byte_valid && byte_ready. byte_ready is high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK and is registered (state-decoded), never combinational from byte_valid.
- IDLE: core_reset=1. start -> LEN_HI. imem_addr<=0. word count<=0.
- LEN_HI / LEN_LO: capture the 16-bit word count N, big-endian. After LEN_LO:
  - N=0 -> RELEASE with no writes.
  - N>DEPTH -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI: byte -> imem_data[15:8], then DATA_LO.
- DATA_LO: byte -> imem_data[7:0], then WRITE.
- WRITE, one cycle, byte_ready=0:
  - imem_we=1, imem_addr = current word index.
  - Next cycle: index increments.
  - If index+1==N -> CHK (feature on) or RELEASE; else DATA_HI.
- Minimum throughput: 3 cycles per word when byte_valid is held high.
- RELEASE: core_reset=1. Hold counter counts HOLD_CYCLES cycles, then -> DONE.
- DONE: core_reset=0, done=1. start -> LEN_HI and core_reset=1 in the same cycle as the transition (reload).
- ERROR: core_reset=1, err=1, no writes. start -> LEN_HI (retry, address restarts at 0).
- start is ignored while busy. Stalled byte_valid=0 in any receive state holds state indefinitely; there is no timeout.
- Async reset mid-load: immediate return to IDLE, core_reset=1, imem_we=0. Partially written memory is not cleared.
- imem_addr bits above log2(DEPTH) are always 0. Index never wraps, because N<=DEPTH is checked.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted DATA byte (not length bytes) is maintained, cleared on entry to LEN_HI.
  - After the last WRITE, state CHK accepts one byte. Equal to the running XOR -> RELEASE; else -> ERROR.
  - For N=0 the CHK byte is still required and must be 0x00.
- Not defined: CHK state and XOR register are absent; last WRITE goes straight to RELEASE.

Test Plan:
- Reset then start, stream 00 02 12 34 AB CD with byte_valid held high -> imem_we pulses twice: addr0=0x1234, addr1=0xABCD. core_reset falls exactly HOLD_CYCLES=4 cycles after the second write; done=1.
- Same stream with byte_valid toggling 1/0 every cycle -> identical writes; byte_ready low during WRITE; no byte lost or duplicated.
- Length 01 01 (257 > DEPTH 256) -> ERROR after the second length byte, err=1, no imem_we, core_reset stays 1. A following start with 00 01 00 00 -> addr0=0x0000 written, done=1.
- Length 00 00 -> no writes; done after 4 hold cycles (feature on: requires trailing 0x00).
- Assert reset after the first data byte of a 3-word load -> same cycle: busy=0, core_reset=1, imem_we=0. A new start reloads from address 0.
- LOADER_CHECKSUM_EN: 00 01 12 34 26 -> done. 00 01 12 34 27 -> err=1 and core_reset stays 1.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Boot-time loader in front of the processor core. Receives a
//             byte stream over valid/ready: a big-endian 16-bit word count N,
//             then N big-endian 16-bit instruction words. Each word is
//             written to instruction memory starting at address 0. The core
//             is held in reset while loading and is released HOLD_CYCLES
//             cycles after the final write.
//  Options  : LOADER_CHECKSUM_EN - when defined, a trailing byte must equal
//             the XOR of all data bytes; a mismatch ends in ERROR.
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_data,
  output logic              imem_we,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Hold counter must be able to reach HOLD_CYCLES on the exit cycle.
  localparam int          c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [31:0] c_DEPTH     = 32'(DEPTH);
  localparam logic [31:0] c_HOLD_LAST = 32'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_RELEASE = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHK     = 4'd9
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_count;
  logic [c_HOLD_W-1:0]   r_hold;
  logic                  w_xfer;
  logic                  w_start_ok;
  logic                  w_last_word;
  logic                  w_hold_done;
  logic [15:0]           w_len;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif

  // States in which a byte may be accepted.
  function automatic logic is_rx(input state_t s);
    logic v;
    v = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) || (s == S_DATA_LO);
`ifdef LOADER_CHECKSUM_EN
    v = v || (s == S_CHK);
`endif
    return v;
  endfunction

  // Every state except the three resting states counts as busy.
  function automatic logic is_busy(input state_t s);
    return !((s == S_IDLE) || (s == S_DONE) || (s == S_ERROR));
  endfunction

  assign w_xfer      = byte_valid && byte_ready;
  assign w_start_ok  = start && !is_busy(r_state);
  // Full length as it will look once the low byte is captured this cycle.
  assign w_len       = {r_count[15:8], byte_in};
  assign w_last_word = (32'(imem_addr) + 32'd1) == 32'(r_count);
  assign w_hold_done = 32'(r_hold) == c_HOLD_LAST;

  // Next-state decode; all outputs are registered from this value.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_xfer) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt = S_CHK;
`else
            w_state_nxt = S_RELEASE;
`endif
          end else if (32'(w_len) > c_DEPTH) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (w_xfer) w_state_nxt = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (w_xfer) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = S_CHK;
`else
          w_state_nxt = S_RELEASE;
`endif
        end else begin
          w_state_nxt = S_DATA_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) w_state_nxt = (byte_in == r_xor) ? S_RELEASE : S_ERROR;
      end
`endif
      S_RELEASE: begin
        if (w_hold_done) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, registered status outputs, datapath and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_hold     <= '0;
      imem_addr  <= '0;
      imem_data  <= '0;
      imem_we    <= 1'b0;
      byte_ready <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      byte_ready <= is_rx(w_state_nxt);
      imem_we    <= (w_state_nxt == S_WRITE);
      core_reset <= (w_state_nxt != S_DONE);
      busy       <= is_busy(w_state_nxt);
      done       <= (w_state_nxt == S_DONE);
      err        <= (w_state_nxt == S_ERROR);

      if (r_state == S_RELEASE) r_hold <= r_hold + c_HOLD_W'(1);
      else                      r_hold <= '0;

      // The word index doubles as the write address; it advances after each write.
      if (w_start_ok) begin
        imem_addr <= '0;
        r_count   <= '0;
      end else if (r_state == S_WRITE) begin
        imem_addr <= imem_addr + ADDR_W'(1);
      end

      if (w_xfer) begin
        case (r_state)
          S_LEN_HI:  r_count[15:8]   <= byte_in;
          S_LEN_LO:  r_count[7:0]    <= byte_in;
          S_DATA_HI: imem_data[15:8] <= byte_in;
          S_DATA_LO: imem_data[7:0]  <= byte_in;
          default:   ;
        endcase
      end

`ifdef LOADER_CHECKSUM_EN
      // Running XOR covers data bytes only, never the length header.
      if (w_start_ok) begin
        r_xor <= '0;
      end else if (w_xfer && ((r_state == S_DATA_HI) || (r_state == S_DATA_LO))) begin
        r_xor <= r_xor ^ byte_in;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Directed, table-driven self-checking bench for program_loader.
//             Honours LOADER_CHECKSUM_EN by appending checksum bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int c_HOLD = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit c_CK = 1'b1;
`else
  localparam bit c_CK = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_we;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        err;

  program_loader #(.ADDR_W(16), .DEPTH(256), .HOLD_CYCLES(c_HOLD)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_we    (imem_we),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]       nbytes;
    logic [0:7][7:0]  bytes;
    logic             has_ck;
    logic [7:0]       ck;
    logic             toggle;
    logic [1:0]       nwr;
    logic [0:2][15:0] wdata;
    logic             exp_done;
  } vec_t;

  vec_t vecs [8];
  int   nvec;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  stim_q [$];
  logic [15:0] exp_wd [$];

  // Monitor state, owned by the negedge monitor only.
  int          cyc     = 0;
  int          load_id = 0;
  int          seen_id = 0;
  logic [15:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          rel_cnt;
  int          fall_cyc;
  int          rdy_in_wr;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (seen_id != load_id) begin
      seen_id = load_id;
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      rel_cnt   = 0;
      fall_cyc  = -1;
      rdy_in_wr = 0;
    end
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_data);
      wr_cyc.push_back(cyc);
      if (byte_ready) rdy_in_wr = rdy_in_wr + 1;
    end
    if (busy && !byte_ready && !imem_we) rel_cnt = rel_cnt + 1;
    if (!core_reset && fall_cyc < 0) fall_cyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int nb, input logic [63:0] b, input logic hc,
                              input logic [7:0] ck, input logic tg, input int nwr,
                              input logic [47:0] wd, input logic dn);
    vec_t v;
    v.nbytes   = 4'(nb);
    v.bytes    = b;
    v.has_ck   = hc;
    v.ck       = ck;
    v.toggle   = tg;
    v.nwr      = 2'(nwr);
    v.wdata    = wd;
    v.exp_done = dn;
    return v;
  endfunction

  // Called at posedge+1; leaves the bench at posedge+1 after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    load_id = load_id + 1;
  endtask

  task automatic send_stream(input bit toggle);
    int budget;
    foreach (stim_q[i]) begin
      if (toggle) begin
        byte_valid = 1'b0;
        @(posedge clock); #1;
      end
      byte_in    = stim_q[i];
      byte_valid = 1'b1;
      budget     = 0;
      while (!byte_ready && budget < 100) begin
        @(posedge clock); #1;
        budget++;
      end
      if (!byte_ready) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL byte_ready_timeout actual=0 expected=1 (byte %0d)", i);
        byte_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_load(input string tag, input bit exp_done, input bit held);
    int n;
    int m;
    n = 0;
    while (!(done || err) && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    if (!(done || err)) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL %s finish_timeout actual=busy expected=done_or_err", tag);
    end
    @(negedge clock); #1;
    chk({tag, " done"},       32'(done),       32'(exp_done));
    chk({tag, " err"},        32'(err),        32'(!exp_done));
    chk({tag, " core_reset"}, 32'(core_reset), 32'(!exp_done));
    chk({tag, " busy"},       32'(busy),       32'd0);
    chk({tag, " nwrites"},    32'(wr_data.size()), 32'(exp_wd.size()));
    m = (wr_data.size() < exp_wd.size()) ? wr_data.size() : exp_wd.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
      chk($sformatf("%s data%0d", tag, i), 32'(wr_data[i]), 32'(exp_wd[i]));
    end
    chk({tag, " release_cycles"}, 32'(rel_cnt), exp_done ? 32'(c_HOLD) : 32'd0);
    chk({tag, " core_released"},  32'(fall_cyc >= 0), 32'(exp_done));
    if (exp_done && wr_cyc.size() > 0)
      chk({tag, " hold_after_last_write"},
          32'(fall_cyc - wr_cyc[wr_cyc.size()-1] - 1), 32'(c_HOLD));
    if (held && wr_cyc.size() >= 2)
      chk({tag, " word_spacing"}, 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
    chk({tag, " ready_during_write"}, 32'(rdy_in_wr), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    pulse_start();
    stim_q.delete();
    exp_wd.delete();
    for (int i = 0; i < int'(v.nbytes); i++) stim_q.push_back(v.bytes[i]);
    if (c_CK && v.has_ck) stim_q.push_back(v.ck);
    for (int i = 0; i < int'(v.nwr); i++) exp_wd.push_back(v.wdata[i]);
    send_stream(v.toggle);
    check_load($sformatf("v%0d", k), v.exp_done, !v.toggle);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clock = 1'b0; reset = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;

    vecs[0] = mk(6, 64'h0002_1234_ABCD_0000, 1'b1, 8'h40, 1'b0, 2, 48'h1234_ABCD_0000, 1'b1);
    vecs[1] = mk(6, 64'h0002_1234_ABCD_0000, 1'b1, 8'h40, 1'b1, 2, 48'h1234_ABCD_0000, 1'b1);
    vecs[2] = mk(2, 64'h0101_0000_0000_0000, 1'b0, 8'h00, 1'b0, 0, 48'h0,              1'b0);
    vecs[3] = mk(4, 64'h0001_0000_0000_0000, 1'b1, 8'h00, 1'b0, 1, 48'h0,              1'b1);
    vecs[4] = mk(2, 64'h0000_0000_0000_0000, 1'b1, 8'h00, 1'b0, 0, 48'h0,              1'b1);
    vecs[5] = mk(8, 64'h0003_DEAD_BEEF_0102, 1'b1, 8'h21, 1'b0, 3, 48'hDEAD_BEEF_0102, 1'b1);
    nvec = 6;
`ifdef LOADER_CHECKSUM_EN
    vecs[6] = mk(4, 64'h0001_1234_0000_0000, 1'b1, 8'h26, 1'b0, 1, 48'h1234_0000_0000, 1'b1);
    vecs[7] = mk(4, 64'h0001_1234_0000_0000, 1'b1, 8'h27, 1'b0, 1, 48'h1234_0000_0000, 1'b0);
    nvec = 8;
`endif

    // Reset values while reset is held.
    repeat (3) @(posedge clock);
    #1;
    chk("rst byte_ready", 32'(byte_ready), 32'd0);
    chk("rst imem_we",    32'(imem_we),    32'd0);
    chk("rst imem_addr",  32'(imem_addr),  32'd0);
    chk("rst imem_data",  32'(imem_data),  32'd0);
    chk("rst core_reset", 32'(core_reset), 32'd1);
    chk("rst busy",       32'(busy),       32'd0);
    chk("rst done",       32'(done),       32'd0);
    chk("rst err",        32'(err),        32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("idle core_reset", 32'(core_reset), 32'd1);
    chk("idle byte_ready", 32'(byte_ready), 32'd0);

    for (int k = 0; k < nvec; k++) run_vec(k);

    // Async reset right after the first data byte of a 3-word load.
    pulse_start();
    stim_q = '{8'h00, 8'h03, 8'hDE};
    send_stream(1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst busy",       32'(busy),       32'd0);
    chk("arst core_reset", 32'(core_reset), 32'd1);
    chk("arst imem_we",    32'(imem_we),    32'd0);
    chk("arst byte_ready", 32'(byte_ready), 32'd0);
    chk("arst imem_addr",  32'(imem_addr),  32'd0);
    #3 reset = 1'b0;
    @(posedge clock); #1;
    run_vec(5);

    // start while busy must not restart the load.
    pulse_start();
    stim_q = '{8'h00, 8'h01, 8'h12};
    send_stream(1'b0);
    chk("busy_start busy_before", 32'(busy), 32'd1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    stim_q.delete();
    stim_q.push_back(8'h34);
    if (c_CK) stim_q.push_back(8'h26);
    exp_wd.delete();
    exp_wd.push_back(16'h1234);
    send_stream(1'b0);
    check_load("busy_start", 1'b1, 1'b1);

    // Longest legal load: N = DEPTH = 256.
    pulse_start();
    stim_q.delete();
    exp_wd.delete();
    stim_q.push_back(8'h01);
    stim_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      stim_q.push_back(b);
      stim_q.push_back(~b);
      exp_wd.push_back({b, ~b});
    end
    if (c_CK) stim_q.push_back(8'h00);
    send_stream(1'b0);
    check_load("full_depth", 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
